// File: rtl/cpu_instr_issue.sv
// cpu_instr_issue: instruction/operand latching, PC strobes, jump resolution,
// halt latch, runaway watchdog and retired-instruction counter for the sequencer.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset_n       synchronous active-low reset
//   state_i       current state code from the sequencer
//   bus_in_i      memory data bus
//   zero_flag_i   ALU zero flag
//   opcode_o      instruction register, fed back to the sequencer
//   operand_o     operand register (jump/call target, immediate)
//   reset_cycle_o one-clock pulse ending the current instruction
//   pc_inc_o      step the PC this clock
//   pc_load_o     load the PC from operand_o this clock
//   halted_o      sticky halt
//   wdt_err_o     sticky watchdog error
//   retired_o     retired-instruction count (wraps at 2^16)
module cpu_instr_issue #(
    parameter logic [7:0] ST_FETCH_PC   = 8'h01,
    parameter logic [7:0] ST_FETCH_INST = 8'h02,
    parameter logic [7:0] ST_HALT       = 8'h03,
    parameter logic [7:0] ST_LDI        = 8'h08,
    parameter logic [7:0] ST_JUMP       = 8'h09,
    parameter logic [7:0] ST_TMP_STORE  = 8'h0C,
    parameter logic [7:0] ST_NEXT       = 8'h0F,
    parameter logic [7:0] OP_JMP        = 8'h20,
    parameter logic [7:0] OP_JZ         = 8'h21,
    parameter logic [7:0] OP_JNZ        = 8'h22,
    parameter int         MAX_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  state_i,
    input  logic [7:0]  bus_in_i,
    input  logic        zero_flag_i,
    output logic [7:0]  opcode_o,
    output logic [7:0]  operand_o,
    output logic        reset_cycle_o,
    output logic        pc_inc_o,
    output logic        pc_load_o,
    output logic        halted_o,
    output logic        wdt_err_o,
    output logic [15:0] retired_o
);
    localparam int CW = $clog2(MAX_CYCLES + 2);
    localparam logic [CW-1:0] CMAX = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CSAT = CW'(MAX_CYCLES + 1);
    logic [7:0]    opcode_q, opcode_d, operand_q, operand_d;
    logic          reset_cycle_q, reset_cycle_d, pc_inc_q, pc_inc_d, pc_load_q, pc_load_d;
    logic          halted_q, halted_d, wdt_err_q, wdt_err_d;
    logic [15:0]   retired_q, retired_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          taken, expire;
    assign taken  = (opcode_q == OP_JMP) | ((opcode_q == OP_JZ) & zero_flag_i) |
                    ((opcode_q == OP_JNZ) & ~zero_flag_i);
    assign expire = (cnt_q == CMAX) && (state_i != ST_NEXT);
    always_comb begin
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        halted_d      = halted_q;
        wdt_err_d     = wdt_err_q;
        retired_d     = retired_q;
        cnt_d         = cnt_q;
        reset_cycle_d = 1'b0;
        pc_inc_d      = 1'b0;
        pc_load_d     = 1'b0;
        if (!halted_q) begin
            // Zero means idle after expiry; CSAT means saturated or already retired.
            if (cnt_q != '0 && cnt_q != CSAT) cnt_d = cnt_q + 1'b1;
            if (expire) begin
                reset_cycle_d = 1'b1;
                wdt_err_d     = 1'b1;
                cnt_d         = '0;
            end
            case (state_i)
                ST_FETCH_PC: begin
                    pc_inc_d = 1'b1;
                    cnt_d    = CW'(1);
                end
                ST_FETCH_INST: opcode_d = bus_in_i;
                ST_LDI, ST_TMP_STORE: begin
                    operand_d = bus_in_i;
                    pc_inc_d  = 1'b1;
                end
                ST_JUMP: begin
                    operand_d = bus_in_i;
                    pc_load_d = taken;
                    pc_inc_d  = ~taken;
                end
                ST_NEXT: begin
                    reset_cycle_d = 1'b1;
                    retired_d     = retired_q + 16'd1;
                    // Park the count so a finished instruction cannot trip the watchdog.
                    cnt_d         = CSAT;
                end
                ST_HALT: halted_d = 1'b1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opcode_q      <= '0;
            operand_q     <= '0;
            reset_cycle_q <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            halted_q      <= 1'b0;
            wdt_err_q     <= 1'b0;
            retired_q     <= '0;
            cnt_q         <= '0;
        end else begin
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            reset_cycle_q <= reset_cycle_d;
            pc_inc_q      <= pc_inc_d;
            pc_load_q     <= pc_load_d;
            halted_q      <= halted_d;
            wdt_err_q     <= wdt_err_d;
            retired_q     <= retired_d;
            cnt_q         <= cnt_d;
        end
    end
    assign opcode_o      = opcode_q;
    assign operand_o     = operand_q;
    assign reset_cycle_o = reset_cycle_q;
    assign pc_inc_o      = pc_inc_q;
    assign pc_load_o     = pc_load_q;
    assign halted_o      = halted_q;
    assign wdt_err_o     = wdt_err_q;
    assign retired_o     = retired_q;
endmodule

// File: tb/tb_cpu_instr_issue.sv
// tb_cpu_instr_issue: directed table-driven checks of cpu_instr_issue.
module tb_cpu_instr_issue;
    localparam logic [7:0] FP = 8'h01, FI = 8'h02, HT = 8'h03, LD = 8'h08,
                           JP = 8'h09, TS = 8'h0C, NX = 8'h0F, UK = 8'hEE;
    typedef struct packed {
        logic [63:0] tag;
        logic        rn;
        logic [7:0]  st;
        logic [7:0]  bus;
        logic        zf;
        logic [7:0]  op;
        logic [7:0]  opd;
        logic        rc;
        logic        inc;
        logic        ld;
        logic        hlt;
        logic        wdt;
        logic [15:0] ret;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  state = 8'h00, bus_in = 8'h00;
    logic        zero_flag = 1'b0;
    logic [7:0]  opcode, operand;
    logic        reset_cycle, pc_inc, pc_load, halted, wdt_err;
    logic [15:0] retired;
    int          errors = 0, checks = 0;
    vec_t        vq[$];
    cpu_instr_issue dut (
        .clk(clk), .reset_n(reset_n), .state_i(state), .bus_in_i(bus_in),
        .zero_flag_i(zero_flag), .opcode_o(opcode), .operand_o(operand),
        .reset_cycle_o(reset_cycle), .pc_inc_o(pc_inc), .pc_load_o(pc_load),
        .halted_o(halted), .wdt_err_o(wdt_err), .retired_o(retired)
    );
    always #5 clk = ~clk;
    task automatic add(input logic [63:0] tag, input logic rn, input logic [7:0] st,
                       input logic [7:0] bus, input logic zf, input logic [7:0] op,
                       input logic [7:0] opd, input logic rc, input logic inc, input logic ld,
                       input logic hlt, input logic wdt, input logic [15:0] ret);
        vq.push_back({tag, rn, st, bus, zf, op, opd, rc, inc, ld, hlt, wdt, ret});
    endtask
    task automatic apply(input vec_t t);
        logic [44:0] got, exp;
        reset_n = t.rn; state = t.st; bus_in = t.bus; zero_flag = t.zf;
        @(posedge clk);
        #1;
        got = {opcode, operand, reset_cycle, pc_inc, pc_load, halted, wdt_err, retired};
        exp = {t.op, t.opd, t.rc, t.inc, t.ld, t.hlt, t.wdt, t.ret};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got op=%h opd=%h rc=%b inc=%b ld=%b hlt=%b wdt=%b ret=%h, want op=%h opd=%h rc=%b inc=%b ld=%b hlt=%b wdt=%b ret=%h",
                     t.tag, opcode, operand, reset_cycle, pc_inc, pc_load, halted, wdt_err, retired,
                     t.op, t.opd, t.rc, t.inc, t.ld, t.hlt, t.wdt, t.ret);
        end
    endtask
    initial begin
        //   tag        rn st  bus    zf op     opd    rc inc ld hlt wdt ret
        for (int i = 0; i < 3; i++)
        add("rst",      0, NX, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd0);
        add("rel_nx",   1, NX, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 16'd1);
        add("idle",     1, UK, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        add("ldi_fp",   1, FP, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 16'd1);
        add("ldi_fi",   1, FI, 8'h10, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        add("ldi_op",   1, LD, 8'h5A, 0, 8'h10, 8'h5A, 0, 1, 0, 0, 0, 16'd1);
        add("ldi_nx",   1, NX, 8'h00, 0, 8'h10, 8'h5A, 1, 0, 0, 0, 0, 16'd2);
        add("jz_fp",    1, FP, 8'h00, 0, 8'h10, 8'h5A, 0, 1, 0, 0, 0, 16'd2);
        add("jz_fi",    1, FI, 8'h21, 0, 8'h21, 8'h5A, 0, 0, 0, 0, 0, 16'd2);
        add("jz_tkn",   1, JP, 8'h40, 1, 8'h21, 8'h40, 0, 0, 1, 0, 0, 16'd2);
        add("jz_nx",    1, NX, 8'h00, 0, 8'h21, 8'h40, 1, 0, 0, 0, 0, 16'd3);
        add("jz2_fp",   1, FP, 8'h00, 0, 8'h21, 8'h40, 0, 1, 0, 0, 0, 16'd3);
        add("jz2_fi",   1, FI, 8'h21, 0, 8'h21, 8'h40, 0, 0, 0, 0, 0, 16'd3);
        add("jz_ntkn",  1, JP, 8'h40, 0, 8'h21, 8'h40, 0, 1, 0, 0, 0, 16'd3);
        add("jz2_nx",   1, NX, 8'h00, 0, 8'h21, 8'h40, 1, 0, 0, 0, 0, 16'd4);
        add("jnz_fi",   1, FI, 8'h22, 0, 8'h22, 8'h40, 0, 0, 0, 0, 0, 16'd4);
        add("jnz_z1",   1, JP, 8'h41, 1, 8'h22, 8'h41, 0, 1, 0, 0, 0, 16'd4);
        add("jnz_z0",   1, JP, 8'h42, 0, 8'h22, 8'h42, 0, 0, 1, 0, 0, 16'd4);
        add("jmp_fi",   1, FI, 8'h20, 0, 8'h20, 8'h42, 0, 0, 0, 0, 0, 16'd4);
        add("jmp_z0",   1, JP, 8'h43, 0, 8'h20, 8'h43, 0, 0, 1, 0, 0, 16'd4);
        add("jmp_z1",   1, JP, 8'h44, 1, 8'h20, 8'h44, 0, 0, 1, 0, 0, 16'd4);
        add("jmp_nx",   1, NX, 8'h00, 0, 8'h20, 8'h44, 1, 0, 0, 0, 0, 16'd5);
        add("tmp_st",   1, TS, 8'h77, 0, 8'h20, 8'h77, 0, 1, 0, 0, 0, 16'd5);
        add("wdt_fp",   1, FP, 8'h00, 0, 8'h20, 8'h77, 0, 1, 0, 0, 0, 16'd5);
        for (int i = 0; i < 7; i++)
        add("wdt_cnt",  1, UK, 8'h00, 0, 8'h20, 8'h77, 0, 0, 0, 0, 0, 16'd5);
        add("wdt_fire", 1, UK, 8'h00, 0, 8'h20, 8'h77, 1, 0, 0, 0, 1, 16'd5);
        add("wdt_once", 1, UK, 8'h00, 0, 8'h20, 8'h77, 0, 0, 0, 0, 1, 16'd5);
        add("wdt_frz",  1, UK, 8'h00, 0, 8'h20, 8'h77, 0, 0, 0, 0, 1, 16'd5);
        add("rst_mid",  0, FP, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd0);
        add("wdn_fp",   1, FP, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 7; i++)
        add("wdn_cnt",  1, UK, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd0);
        add("wdn_nx",   1, NX, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 16'd1);
        for (int i = 0; i < 9; i++)
        add("wdn_quiet",1, UK, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        add("hlt_fi",   1, FI, 8'h33, 0, 8'h33, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        add("hlt",      1, HT, 8'h00, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_fp",   1, FP, 8'h00, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_nx",   1, NX, 8'h00, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_fi2",  1, FI, 8'h99, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_ldi",  1, LD, 8'h55, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_jmp",  1, JP, 8'h66, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_rep",  1, HT, 8'h00, 0, 8'h33, 8'h00, 0, 0, 0, 1, 0, 16'd1);
        add("hlt_rst",  0, NX, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 16'd0);
        foreach (vq[i]) apply(vq[i]);
        // Drive the counter to 16'hFFFF by retiring 65535 instructions, then wrap it.
        reset_n = 1'b1; state = NX;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        apply({"wrap_max", 1'b1, NX, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF});
        apply({"wrap_0",   1'b1, NX, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        apply({"wrap_end", 1'b1, UK, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
